// File: rtl/usrp_tag_tx_frame_ctrl_if.sv
// Stream bundle between the tag frame sequencer, its payload generator and
// the radio TX sample path.
//   pay_*  : payload stream into the sequencer, plus the generator sync reset
//   o_*    : framed {I,Q} sample stream out of the sequencer
// master = sequencer side, slave = generator / radio side.
interface usrp_tag_tx_frame_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [2*DATA_WIDTH-1:0] pay_tdata;
    logic                    pay_tvalid;
    logic                    pay_tlast;
    logic                    pay_tready;
    logic                    pay_srst;
    logic [2*DATA_WIDTH-1:0] o_tdata;
    logic                    o_tvalid;
    logic                    o_tready;

    modport master (
        input  pay_tdata, pay_tvalid, pay_tlast, o_tready,
        output pay_tready, pay_srst, o_tdata, o_tvalid
    );

    modport slave (
        output pay_tdata, pay_tvalid, pay_tlast, o_tready,
        input  pay_tready, pay_srst, o_tdata, o_tvalid
    );
endinterface

// File: rtl/usrp_tag_tx_frame_ctrl.sv
// Tag transmit sequencer: bursts of settle -> BPSK preamble -> gap -> payload.
// Ports: clk, reset (async active-low), start/abort/continuous/nframes control,
// prmb_addr/prmb_bit preamble ROM lookup, bus (payload in / samples out),
// fp_gpio_out/fp_gpio_ddr markers, tx_state/frame_count/busy/done status.
module usrp_tag_tx_frame_ctrl #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned GPIO_REG_WIDTH = 12,
    parameter int unsigned NPRMB_BITS     = 2046,
    parameter int unsigned PRMB_OS        = 256,
    parameter int unsigned NGAP           = 32768,
    parameter int unsigned SETTLE_CYC     = 32,
    parameter int unsigned AMP            = 16384,
    parameter int unsigned NFRAME_WIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          continuous,
    input  logic [NFRAME_WIDTH-1:0]       nframes,
    output logic [$clog2(NPRMB_BITS)-1:0] prmb_addr,
    input  logic                          prmb_bit,
    usrp_tag_tx_frame_ctrl_if.master      bus,
    output logic [GPIO_REG_WIDTH-1:0]     fp_gpio_out,
    output logic [GPIO_REG_WIDTH-1:0]     fp_gpio_ddr,
    output logic [2:0]                    tx_state,
    output logic [NFRAME_WIDTH-1:0]       frame_count,
    output logic                          busy,
    output logic                          done
);
    localparam int unsigned AW   = $clog2(NPRMB_BITS);
    localparam int unsigned OSW  = (PRMB_OS > 1) ? $clog2(PRMB_OS) : 1;
    localparam int unsigned CMAX = (NGAP > SETTLE_CYC) ? NGAP : SETTLE_CYC;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam int unsigned SW   = 2 * DATA_WIDTH;
    localparam int unsigned FW   = NFRAME_WIDTH;
    localparam logic [DATA_WIDTH-1:0] POS = DATA_WIDTH'(AMP);
    localparam logic [DATA_WIDTH-1:0] NEG = ~POS + DATA_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETTLE   = 3'd1,
        PREAMBLE = 3'd2,
        GAP      = 3'd3,
        PAYLOAD  = 3'd4
    } state_t;

    state_t          r_state, w_state;
    logic [OSW-1:0]  r_os, w_os;
    logic [AW-1:0]   r_addr, w_addr;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic            r_cont, w_cont;
    logic [FW-1:0]   r_nfr, w_nfr;
    logic [FW-1:0]   r_fc, w_fc;
    logic            r_done, w_done;
    logic            r_tvalid, w_tvalid;
    logic [SW-1:0]   r_tdata, w_tdata;
    logic            r_srst;
    logic [2:0]      r_gpio;
    logic            w_ld;
    logic            w_pay_tready_c;
    logic            w_xfer;
    logic [FW:0]     w_fc_inc;

    // Output register may take a new beat when empty or being drained.
    assign w_ld     = !r_tvalid || bus.o_tready;
    assign w_xfer   = bus.pay_tvalid && w_pay_tready_c;
    assign w_fc_inc = {1'b0, r_fc} + (FW+1)'(1);

    // Next-state and next-register computation.
    always_comb begin
        w_state        = r_state;
        w_os           = r_os;
        w_addr         = r_addr;
        w_cnt          = r_cnt;
        w_cont         = r_cont;
        w_nfr          = r_nfr;
        w_fc           = r_fc;
        w_done         = 1'b0;
        w_tvalid       = w_ld ? 1'b0 : r_tvalid;
        w_tdata        = r_tdata;
        w_pay_tready_c = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_cont  = continuous;
                    w_nfr   = (nframes == '0) ? FW'(1) : nframes;
                    w_fc    = '0;
                    w_cnt   = '0;
                    w_state = SETTLE;
                end
            end
            SETTLE: begin
                if (r_cnt == CW'(SETTLE_CYC - 1)) begin
                    w_cnt   = '0;
                    w_state = PREAMBLE;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            PREAMBLE: begin
                if (w_ld) begin
                    w_tvalid = 1'b1;
                    w_tdata  = prmb_bit ? {POS, POS} : {NEG, NEG};
                    if (r_os == OSW'(PRMB_OS - 1)) begin
                        w_os = '0;
                        if (r_addr == AW'(NPRMB_BITS - 1)) begin
                            w_addr  = '0;
                            w_cnt   = '0;
                            w_state = GAP;
                        end else begin
                            w_addr = r_addr + AW'(1);
                        end
                    end else begin
                        w_os = r_os + OSW'(1);
                    end
                end
            end
            GAP: begin
                if (r_cnt == CW'(NGAP - 1)) begin
                    w_cnt   = '0;
                    w_state = PAYLOAD;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            PAYLOAD: begin
                w_pay_tready_c = w_ld;
                if (w_xfer) begin
                    w_tvalid = 1'b1;
                    w_tdata  = bus.pay_tdata;
                    if (bus.pay_tlast) begin
                        w_fc = r_fc + FW'(1);
                        if (r_cont || (w_fc_inc < {1'b0, r_nfr})) begin
                            w_cnt   = '0;
                            w_state = SETTLE;
                        end else begin
                            w_done  = 1'b1;
                            w_state = IDLE;
                        end
                    end
                end
            end
            default: w_state = IDLE;
        endcase

        // Abort overrides everything; frame_count keeps its value.
        if (abort) begin
            w_state        = IDLE;
            w_tvalid       = 1'b0;
            w_os           = '0;
            w_addr         = '0;
            w_cnt          = '0;
            w_fc           = r_fc;
            w_done         = 1'b0;
            w_pay_tready_c = 1'b0;
        end
    end

    // State and datapath registers; markers follow the next state so they
    // line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_os     <= '0;
            r_addr   <= '0;
            r_cnt    <= '0;
            r_cont   <= 1'b0;
            r_nfr    <= '0;
            r_fc     <= '0;
            r_done   <= 1'b0;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_srst   <= 1'b0;
            r_gpio   <= '0;
        end else begin
            r_state  <= w_state;
            r_os     <= w_os;
            r_addr   <= w_addr;
            r_cnt    <= w_cnt;
            r_cont   <= w_cont;
            r_nfr    <= w_nfr;
            r_fc     <= w_fc;
            r_done   <= w_done;
            r_tvalid <= w_tvalid;
            r_tdata  <= w_tdata;
            r_srst   <= (w_state == GAP);
            r_gpio   <= {(w_state == SETTLE) && (r_state != SETTLE),
                         (w_state == PAYLOAD),
                         (w_state == PREAMBLE)};
        end
    end

    assign bus.o_tdata    = r_tdata;
    assign bus.o_tvalid   = r_tvalid;
    assign bus.pay_srst   = r_srst;
    assign bus.pay_tready = w_pay_tready_c;
    assign prmb_addr      = r_addr;
    assign fp_gpio_out    = GPIO_REG_WIDTH'(r_gpio);
    assign fp_gpio_ddr    = GPIO_REG_WIDTH'(3'b111);
    assign tx_state       = r_state;
    assign frame_count    = r_fc;
    assign busy           = (r_state != IDLE);
    assign done           = r_done;
endmodule

// File: doc/usrp_tag_tx_frame_ctrl.md
Name: usrp_tag_tx_frame_ctrl

Overview:
Next-generation tag transmit sequencer: emits framed bursts of settle → BPSK preamble → gap → payload. Preamble length, oversampling, gap length and amplitude are parametrised. Supports a programmable frame count or continuous mode, abort, and full valid/ready backpressure on both the payload input and the sample output. Sits between the multitone/chip payload generator (reset via pay_srst) and the radio TX sample path; also drives front-panel GPIO markers.

Parameters:
DATA_WIDTH, 16, width of each I and Q sample
GPIO_REG_WIDTH, 12, front-panel GPIO register width (>=3)
NPRMB_BITS, 2046, preamble length in bits
PRMB_OS, 256, samples per preamble bit
NGAP, 32768, gap length in clock cycles
SETTLE_CYC, 32, settle cycles at frame start
AMP, 16384, BPSK magnitude; bit 1 → +AMP, bit 0 → -AMP, applied to both I and Q
NFRAME_WIDTH, 8, width of frame count/counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle start request; ignored while busy
abort  in  1  stop immediately and return to IDLE
continuous  in  1  sampled at start; 1 = repeat frames until abort
nframes  in  NFRAME_WIDTH  sampled at start; frames per burst, 0 treated as 1
prmb_addr  out  clog2(NPRMB_BITS)  preamble bit index
prmb_bit  in  1  preamble bit at prmb_addr, valid in the same cycle (combinational ROM)
pay_srst  out  1  payload generator sync reset
pay_tdata  in  2*DATA_WIDTH  {I,Q} payload sample
pay_tvalid  in  1  payload valid
pay_tlast  in  1  last payload sample of the frame
pay_tready  out  1  payload ready
o_tdata  out  2*DATA_WIDTH  {I,Q} output sample
o_tvalid  out  1  output valid
o_tready  in  1  output ready
fp_gpio_out  out  GPIO_REG_WIDTH  markers
fp_gpio_ddr  out  GPIO_REG_WIDTH  constant: bits[2:0]=1, others 0
tx_state  out  3  state code
frame_count  out  NFRAME_WIDTH  frames completed in the current burst
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when a burst completes normally

Behaviour:
- Reset (async assert, sync release): state IDLE; o_tvalid=0; o_tdata=0; pay_srst=0; pay_tready=0; prmb_addr=0; frame_count=0; done=0; fp_gpio_out=0. All internal counters are 0.
- States and codes: IDLE 0, SETTLE 1, PREAMBLE 2, GAP 3, PAYLOAD 4.
- Output register load enable: ld = !o_tvalid || o_tready. o_tvalid is registered.
- IDLE: on start (and not abort), latch continuous and nframes, clear frame_count, go to SETTLE.
- SETTLE: count exactly SETTLE_CYC cycles, then PREAMBLE. No output in this state.
- PREAMBLE:
  - Each cycle with ld=1, load ±AMP per prmb_bit into the output register and set o_tvalid=1. os_count advances only on ld.
  - When os_count reaches PRMB_OS-1, wrap it and advance prmb_addr.
  - After exactly NPRMB_BITS*PRMB_OS loads, go to GAP with prmb_addr=0.
  - A stalled o_tready freezes both counters.
- GAP:
  - Once the pending output beat drains, o_tvalid=0.
  - pay_srst=1 for all NGAP cycles; the cycle count is independent of o_tready.
  - Then go to PAYLOAD.
- PAYLOAD:
  - pay_tready = ld. A transfer (pay_tvalid && pay_tready) loads pay_tdata with o_tvalid=1.
  - A transfer with pay_tlast increments frame_count and ends the frame.
  - Frame end: if continuous, or frame_count+1 < max(nframes,1), go to SETTLE; otherwise go to IDLE with a done pulse.
  - The last beat stays held until accepted.
- GPIO markers: bit0=1 in PREAMBLE, bit1=1 in PAYLOAD, bit2 = one-cycle pulse on SETTLE entry. All are registered.
- Abort (any state, highest priority, wins over simultaneous start or frame end):
  - Next state IDLE; o_tvalid=0; pay_srst=0; counters cleared; done stays 0.
  - frame_count holds its value.
- Continuous mode: frame_count wraps modulo 2^NFRAME_WIDTH.
- Latency: one cycle from ld to a valid o_tdata beat. Payload input to output is one register stage.

Test Plan:
- Params NPRMB_BITS=4, PRMB_OS=2, NGAP=5, SETTLE_CYC=3, AMP=100; bits 1,0,1,1; o_tready=1; start with nframes=1; payload 3 beats, last on beat 3 → output +100,+100,-100,-100,+100,+100,+100,+100 then the 3 payload beats; pay_srst high for exactly 5 cycles; done pulses once; frame_count=1.
- Same setup with o_tready toggling 1,0 → 8 preamble beats total, each held stable while stalled; no beat lost or duplicated.
- nframes=3 → three SETTLE entries (gpio bit2 pulses 3 times), frame_count ends at 3, single done; nframes=0 behaves as 1.
- continuous=1 → frames repeat past 3; abort mid-PREAMBLE → IDLE next cycle, o_tvalid=0, no done pulse.
- start asserted while busy → ignored; start and abort in the same cycle from IDLE → stays IDLE.
- Reset asserted mid-PAYLOAD → all outputs return to reset values immediately, without waiting for a clock edge.
